bp_cfg_runtime_regs: RTL
========================

# bp_cfg_runtime_regs

Runtime configuration register file that replaces compile-time-only per-core settings with software-writable values delivered over a ready/valid command link. Holds a shadow copy and an active copy of each core's configuration and transfers shadow to active on an explicit commit. Releases cores from freeze in a staggered sequence to bound simultaneous wake-up. Sits between the host/IO config endpoint and the core tiles; its outputs drive each tile's freeze, core id and cache/CCE mode inputs.

## Interface
- num_core_p, 1: number of core channels (1..16)
- core_id_width_p, 4: width of each core id field
- cfg_data_width_p, 32: command/response data width
- release_gap_p, 4: cycles between successive unfreezes (>=1)
- clk_i  in  1  clock
- reset_n_i  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_v_i  in  1  command valid
- cmd_w_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  8  {core_idx[7:4], reg_sel[3:0]}
- cmd_data_i  in  cfg_data_width_p  write data
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
- resp_v_o  out  1  read response valid
- resp_data_o  out  cfg_data_width_p  read data, zero-extended
- resp_yumi_i  in  1  consumer takes response (only legal while resp_v_o)
- freeze_o  out  num_core_p  active per-core freeze
- core_id_o  out  num_core_p*core_id_width_p  active core ids
- icache_mode_o, dcache_mode_o  out  num_core_p*2  active cache modes
- cce_mode_o  out  num_core_p  active CCE mode (0 uncached, 1 normal)
- busy_o  out  1  commit/release sequence in progress

## Operation
- reg_sel: 0 freeze (data[0]), 1 core_id, 2 icache_mode (data[1:0]), 3 dcache_mode, 4 cce_mode, 14 STATUS (read: data[0]=busy, global), 15 COMMIT (write data[0]=1, global; data[0]=0 ignored). Other reg_sel: writes dropped, reads return 0.
- core_idx >= num_core_p: per-core writes dropped, reads return 0.
- Writes update shadow only; per-core reads return shadow values; no response for writes.
- FSM states IDLE, COMMIT, RELEASE. IDLE -> COMMIT on accepted COMMIT write. COMMIT: copy shadow core_id/modes to active; cores with shadow freeze=1 freeze immediately; cores with shadow freeze=0 and active freeze=1 set their pending-release bit; -> RELEASE if any pending, else IDLE. RELEASE: clear the freeze of the lowest-index pending core, clear its pending bit, wait release_gap_p cycles before the next; -> IDLE after last release.
- cmd_ready_o = (state==IDLE) & ~resp_v_o.
- Reset values: shadow and active freeze all 1, core_id[i]=i (truncated to core_id_width_p), modes 0, pending 0, resp_v_o 0, resp_data_o 0, busy_o 0, cmd_ready_o 1 after reset release, state IDLE.

## Timing
- Read accepted in cycle t -> resp_v_o=1 with data in t+1; held stable until the cycle resp_yumi_i=1, cleared the following cycle; next command accepted no earlier than that cycle.
- Write accepted in cycle t -> shadow visible to a read accepted in t+1.
- COMMIT accepted in cycle t -> state COMMIT in t+1; core_id/mode outputs and new freezes change in t+2; first unfreeze in t+2; each subsequent unfreeze release_gap_p cycles after the previous; busy_o high t+1 through the cycle of the last unfreeze.
- Commit with nothing pending: busy_o high only in t+1; cmd_ready_o high again in t+2.
- Gap counter width clog2(release_gap_p+1); reloads on each unfreeze; no wrap.
- reset_n_i asserted mid-sequence: all state and outputs return to reset values asynchronously; pending releases discarded; an in-flight response is lost.

## Structure
- Shared package bp_cfg_runtime_pkg: reg_sel enum, FSM state enum, mode field widths, address field widths.
- One sub-module bp_cfg_release_seq: pending vector, lowest-index priority select, gap counter, emits one-hot release strobe and done.

## Test plan
- Reset, num_core_p=4: freeze_o=4'b1111, core_id_o={3,2,1,0}, modes 0, cmd_ready_o=1, resp_v_o=0.
- Write core 2 icache_mode=2'b10, read back -> resp_data_o=2 in t+1; icache_mode_o unchanged until COMMIT, then core 2 field =2 in commit+2.
- Clear freeze for cores 0,1,3, COMMIT, release_gap_p=4 -> freeze_o bits drop at commit+2, +6, +10 in order 0,1,3; busy_o falls after core 3; core 2 stays frozen.
- Hold resp_yumi_i=0 for 5 cycles after a read -> resp_v_o/data stable, cmd_ready_o=0 throughout; command accepted the cycle yumi asserts... next cycle.
- Write/read core_idx=7 with num_core_p=4 and reg_sel=9 -> no state change, reads return 0.
- Assert reset_n_i during RELEASE -> freeze_o=all 1, busy_o=0 immediately; after release, a new COMMIT sequences from scratch.

Source files
------------

// File: rtl/bp_cfg_runtime_pkg.sv
// Shared types and field widths for the runtime per-core configuration register file.
package bp_cfg_runtime_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned CORE_IDX_W = 4;
  localparam int unsigned REG_SEL_W  = 4;
  localparam int unsigned MODE_W     = 2;

  typedef enum logic [REG_SEL_W-1:0] {
    REG_FREEZE  = 4'd0,
    REG_CORE_ID = 4'd1,
    REG_ICACHE  = 4'd2,
    REG_DCACHE  = 4'd3,
    REG_CCE     = 4'd4,
    REG_STATUS  = 4'd14,
    REG_COMMIT  = 4'd15
  } reg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMMIT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CORE_IDX_W-1:0] core_idx;
    logic [REG_SEL_W-1:0]  reg_sel;
  } cfg_addr_t;

endpackage

// File: rtl/bp_cfg_runtime_regs_if.sv
// Command/response link between the host config endpoint and the register file.
interface bp_cfg_runtime_regs_if
  import bp_cfg_runtime_pkg::*;
#(
  parameter int unsigned cfg_data_width_p = 32
);

  logic                        cmd_v_i;
  logic                        cmd_w_i;
  logic [ADDR_W-1:0]           cmd_addr_i;
  logic [cfg_data_width_p-1:0] cmd_data_i;
  logic                        cmd_ready_o;
  logic                        resp_v_o;
  logic [cfg_data_width_p-1:0] resp_data_o;
  logic                        resp_yumi_i;

  modport master (
    output cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
    input  cmd_ready_o, resp_v_o, resp_data_o
  );

  modport slave (
    input  cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
    output cmd_ready_o, resp_v_o, resp_data_o
  );

endinterface

// File: rtl/bp_cfg_release_seq.sv
// Staggered unfreeze sequencer: lowest-index pending core first, fixed gap between releases.
module bp_cfg_release_seq #(
  parameter int unsigned num_core_p    = 1,
  parameter int unsigned release_gap_p = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [num_core_p-1:0] mask,
  output logic [num_core_p-1:0] release_c,
  output logic                  done_c
);

  localparam int unsigned N     = num_core_p;
  localparam int unsigned CNT_W = $clog2(release_gap_p + 1);

  logic [N-1:0]     pending;
  logic [N-1:0]     cand;
  logic [CNT_W-1:0] gap_cnt;

  // A load releases its first core immediately; afterwards wait for the gap to expire.
  always_comb begin
    cand      = '0;
    if (load) begin
      cand = mask;
    end else if (gap_cnt == '0) begin
      cand = pending;
    end
    release_c = cand & (~cand + N'(1));
    done_c    = ~|pending;
  end

  // Pending vector and gap counter; counter reloads on every release and stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      gap_cnt <= '0;
    end else begin
      pending <= (load ? mask : pending) & ~release_c;
      if (|release_c) begin
        gap_cnt <= CNT_W'(release_gap_p - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bp_cfg_runtime_regs.sv
// Per-core shadow/active configuration registers with commit and staggered unfreeze.
module bp_cfg_runtime_regs
  import bp_cfg_runtime_pkg::*;
#(
  parameter int unsigned num_core_p       = 1,
  parameter int unsigned core_id_width_p  = 4,
  parameter int unsigned cfg_data_width_p = 32,
  parameter int unsigned release_gap_p    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  bp_cfg_runtime_regs_if.slave                  cfg,
  output logic [num_core_p-1:0]                 freeze_o,
  output logic [num_core_p*core_id_width_p-1:0] core_id_o,
  output logic [num_core_p*MODE_W-1:0]          icache_mode_o,
  output logic [num_core_p*MODE_W-1:0]          dcache_mode_o,
  output logic [num_core_p-1:0]                 cce_mode_o,
  output logic                                  busy_o
);

  localparam int unsigned N     = num_core_p;
  localparam int unsigned IW    = core_id_width_p;
  localparam int unsigned DW    = cfg_data_width_p;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  state_e            state;
  logic              busy;
  logic              resp_v;
  logic [DW-1:0]     resp_data;
  logic [N-1:0]      sh_freeze, act_freeze, sh_cce, act_cce;
  logic [IW-1:0]     sh_id  [N];
  logic [IW-1:0]     act_id [N];
  logic [MODE_W-1:0] sh_ic  [N];
  logic [MODE_W-1:0] act_ic [N];
  logic [MODE_W-1:0] sh_dc  [N];
  logic [MODE_W-1:0] act_dc [N];

  cfg_addr_t         addr;
  logic [IDX_W-1:0]  idx;
  logic              idx_ok, accept, commit_go, load, done_c;
  logic [N-1:0]      rel_mask_c, release_c;
  logic [DW-1:0]     rd_data_c;

  assign addr            = cfg.cmd_addr_i;
  assign idx             = IDX_W'(addr.core_idx);
  assign idx_ok          = 32'(addr.core_idx) < N;
  assign cfg.cmd_ready_o = (state == ST_IDLE) & ~resp_v;
  assign accept          = cfg.cmd_v_i & cfg.cmd_ready_o;
  assign commit_go       = accept & cfg.cmd_w_i & (addr.reg_sel == REG_COMMIT) & cfg.cmd_data_i[0];
  assign load            = (state == ST_COMMIT);
  assign rel_mask_c      = ~sh_freeze & act_freeze;

  bp_cfg_release_seq #(
    .num_core_p   (N),
    .release_gap_p(release_gap_p)
  ) u_seq (
    .clk      (clk_i),
    .rst_n    (reset_n_i),
    .load     (load),
    .mask     (rel_mask_c),
    .release_c(release_c),
    .done_c   (done_c)
  );

  // Read mux over shadow values; unmapped selects and absent cores read as zero.
  always_comb begin
    rd_data_c = '0;
    case (reg_sel_e'(addr.reg_sel))
      REG_FREEZE:  if (idx_ok) rd_data_c = DW'(sh_freeze[idx]);
      REG_CORE_ID: if (idx_ok) rd_data_c = DW'(sh_id[idx]);
      REG_ICACHE:  if (idx_ok) rd_data_c = DW'(sh_ic[idx]);
      REG_DCACHE:  if (idx_ok) rd_data_c = DW'(sh_dc[idx]);
      REG_CCE:     if (idx_ok) rd_data_c = DW'(sh_cce[idx]);
      REG_STATUS:  rd_data_c = DW'(busy);
      default:     rd_data_c = '0;
    endcase
  end

  // Command handling, response holding and the IDLE/COMMIT/RELEASE control.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      resp_v     <= 1'b0;
      resp_data  <= '0;
      sh_freeze  <= '1;
      act_freeze <= '1;
      sh_cce     <= '0;
      act_cce    <= '0;
      for (int i = 0; i < N; i++) begin
        sh_id[i]  <= IW'(i);
        act_id[i] <= IW'(i);
        sh_ic[i]  <= '0;
        act_ic[i] <= '0;
        sh_dc[i]  <= '0;
        act_dc[i] <= '0;
      end
    end else begin
      if (resp_v && cfg.resp_yumi_i) begin
        resp_v <= 1'b0;
      end
      if (accept && !cfg.cmd_w_i) begin
        resp_v    <= 1'b1;
        resp_data <= rd_data_c;
      end
      if (accept && cfg.cmd_w_i && idx_ok) begin
        case (reg_sel_e'(addr.reg_sel))
          REG_FREEZE:  sh_freeze[idx] <= cfg.cmd_data_i[0];
          REG_CORE_ID: sh_id[idx]     <= cfg.cmd_data_i[IW-1:0];
          REG_ICACHE:  sh_ic[idx]     <= cfg.cmd_data_i[MODE_W-1:0];
          REG_DCACHE:  sh_dc[idx]     <= cfg.cmd_data_i[MODE_W-1:0];
          REG_CCE:     sh_cce[idx]    <= cfg.cmd_data_i[0];
          default:     ;
        endcase
      end
      case (state)
        ST_IDLE: begin
          if (commit_go) begin
            state <= ST_COMMIT;
            busy  <= 1'b1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < N; i++) begin
            act_id[i] <= sh_id[i];
            act_ic[i] <= sh_ic[i];
            act_dc[i] <= sh_dc[i];
          end
          act_cce    <= sh_cce;
          // Newly frozen cores freeze now; the first pending core is released in the same edge.
          act_freeze <= (sh_freeze | act_freeze) & ~release_c;
          if (|rel_mask_c) begin
            state <= ST_RELEASE;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RELEASE: begin
          act_freeze <= act_freeze & ~release_c;
          if (done_c) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.resp_v_o    = resp_v;
  assign cfg.resp_data_o = resp_data;
  assign busy_o          = busy;
  assign freeze_o        = act_freeze;
  assign cce_mode_o      = act_cce;

  for (genvar i = 0; i < N; i++) begin : g_out
    assign core_id_o[i*IW +: IW]             = act_id[i];
    assign icache_mode_o[i*MODE_W +: MODE_W] = act_ic[i];
    assign dcache_mode_o[i*MODE_W +: MODE_W] = act_dc[i];
  end

endmodule
